// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: decodes UART command frames into register-file accesses and ALU launches,
// streaming read data and multi-byte ALU results into the TX FIFO with timeout and error pulses.
module sys_ctrl_burst #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int MAX_BURST      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic                     FIFO_FULL,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                     EN,
  output logic                     CLK_EN,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     W_INC,
  output logic                     clk_div_en,
  output logic                     BUSY,
  output logic                     ERR
);
  localparam int NBYTES = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int ACW    = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);
  localparam logic [DATA_WIDTH-1:0] CMD_BWR    = DATA_WIDTH'(8'hEE);
  localparam logic [DATA_WIDTH-1:0] CMD_BRD    = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] MAX_LEN    = DATA_WIDTH'(MAX_BURST);
  localparam logic [DATA_WIDTH-1:0] CNT_ONE    = DATA_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ACW-1:0]        ALU_BYTES  = ACW'(NBYTES);
  localparam logic [ACW-1:0]        ACNT_ONE   = ACW'(1);
  localparam logic [TW-1:0]         TMR_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]         TMR_ONE    = TW'(1);

  typedef enum logic [3:0] {
    IDLE, ADDR, LEN, WDATA, OPA, OPB, FUN, ALU_WAIT, ALU_TX, RD_REQ, RD_WAIT, RD_TX
  } state_t;

  state_t                   state_q, state_d;
  logic                     err_d, timeout_hit;
  logic [DATA_WIDTH-1:0]    cmd_q, cnt_q, rd_q;
  logic [ADDR_WIDTH-1:0]    ptr_q;
  logic [ALU_OUT_WIDTH-1:0] alu_sh_q, alu_src;
  logic [ACW-1:0]           alu_cnt_q, alu_left;
  logic [TW-1:0]            timer_q;
  logic                     rd_push, alu_push;
  logic [DATA_WIDTH-1:0]    rd_byte;

  logic [ALU_FUN_WIDTH-1:0] alu_fun_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wrdata_q, tx_q;
  logic                     en_q, clk_en_q, wren_q, rden_q, winc_q, busy_q, err_q;

  // First byte of a result or read may be pushed straight from the input when the FIFO has room.
  assign rd_push  = !FIFO_FULL && ((state_q == RD_WAIT && RdData_Valid) || state_q == RD_TX);
  assign rd_byte  = (state_q == RD_WAIT) ? RdData : rd_q;
  assign alu_push = !FIFO_FULL && ((state_q == ALU_WAIT && OUT_Valid) || state_q == ALU_TX);
  assign alu_src  = (state_q == ALU_WAIT) ? ALU_OUT : alu_sh_q;
  assign alu_left = (state_q == ALU_WAIT) ? ALU_BYTES : alu_cnt_q;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (RX_D_VLD) begin
        if (RX_P_DATA == CMD_WR || RX_P_DATA == CMD_RD || RX_P_DATA == CMD_BWR || RX_P_DATA == CMD_BRD)
          state_d = ADDR;
        else if (RX_P_DATA == CMD_ALU_OP) state_d = OPA;
        else if (RX_P_DATA == CMD_ALU)    state_d = FUN;
        else                              err_d   = 1'b1;
      end
      ADDR: if (RX_D_VLD)
        state_d = (cmd_q == CMD_WR) ? WDATA : (cmd_q == CMD_RD) ? RD_REQ : LEN;
      LEN: if (RX_D_VLD) begin
        if (RX_P_DATA == '0) state_d = IDLE;
        else if (RX_P_DATA > MAX_LEN) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else state_d = (cmd_q == CMD_BWR) ? WDATA : RD_REQ;
      end
      WDATA:    if (RX_D_VLD && cnt_q == CNT_ONE) state_d = IDLE;
      OPA:      if (RX_D_VLD) state_d = OPB;
      OPB:      if (RX_D_VLD) state_d = FUN;
      FUN:      if (RX_D_VLD) state_d = ALU_WAIT;
      ALU_WAIT: if (OUT_Valid) state_d = (alu_push && alu_left == ACNT_ONE) ? IDLE : ALU_TX;
      ALU_TX:   if (alu_push && alu_left == ACNT_ONE) state_d = IDLE;
      RD_REQ:   state_d = RD_WAIT;
      RD_WAIT, RD_TX: begin
        if (rd_push) state_d = (cnt_q == CNT_ONE) ? IDLE : RD_REQ;
        else if (state_q == RD_WAIT && RdData_Valid) state_d = RD_TX;
      end
      default: state_d = IDLE;
    endcase
    timeout_hit = (state_q != IDLE) && (state_d == state_q) && !RX_D_VLD && !FIFO_FULL &&
                  (timer_q == TMR_LAST);
    if (timeout_hit) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      ptr_q     <= '0;
      alu_sh_q  <= '0;
      alu_cnt_q <= '0;
      timer_q   <= '0;
      alu_fun_q <= '0;
      addr_q    <= '0;
      wrdata_q  <= '0;
      tx_q      <= '0;
      en_q      <= 1'b0;
      clk_en_q  <= 1'b0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      winc_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      err_q   <= err_d;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      en_q    <= 1'b0;
      winc_q  <= 1'b0;
      if (RX_D_VLD || state_d != state_q || state_d == IDLE) timer_q <= '0;
      else if (!FIFO_FULL) timer_q <= timer_q + TMR_ONE;

      if (timeout_hit) clk_en_q <= 1'b0;
      else begin
        case (state_q)
          IDLE: if (RX_D_VLD) begin
            cmd_q <= RX_P_DATA;
            if (RX_P_DATA == CMD_ALU_OP || RX_P_DATA == CMD_ALU) clk_en_q <= 1'b1;
          end
          ADDR: if (RX_D_VLD) begin
            ptr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
            addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            cnt_q  <= CNT_ONE;
            if (cmd_q == CMD_RD) begin
              rden_q <= 1'b1;
              ptr_q  <= RX_P_DATA[ADDR_WIDTH-1:0] + ADDR_ONE;
            end
          end
          LEN: if (RX_D_VLD && state_d != IDLE) begin
            cnt_q <= RX_P_DATA;
            if (cmd_q == CMD_BRD) begin
              rden_q <= 1'b1;
              addr_q <= ptr_q;
              ptr_q  <= ptr_q + ADDR_ONE;
            end
          end
          WDATA: if (RX_D_VLD) begin
            wren_q   <= 1'b1;
            addr_q   <= ptr_q;
            wrdata_q <= RX_P_DATA;
            ptr_q    <= ptr_q + ADDR_ONE;
            cnt_q    <= cnt_q - CNT_ONE;
          end
          OPA, OPB: if (RX_D_VLD) begin
            wren_q   <= 1'b1;
            addr_q   <= (state_q == OPA) ? '0 : ADDR_ONE;
            wrdata_q <= RX_P_DATA;
          end
          FUN: if (RX_D_VLD) begin
            alu_fun_q <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
            en_q      <= 1'b1;
          end
          ALU_WAIT, ALU_TX: begin
            if (alu_push) begin
              winc_q    <= 1'b1;
              tx_q      <= alu_src[DATA_WIDTH-1:0];
              alu_sh_q  <= alu_src >> DATA_WIDTH;
              alu_cnt_q <= alu_left - ACNT_ONE;
              if (alu_left == ACNT_ONE) clk_en_q <= 1'b0;
            end else if (state_q == ALU_WAIT && OUT_Valid) begin
              alu_sh_q  <= ALU_OUT;
              alu_cnt_q <= ALU_BYTES;
            end
          end
          RD_WAIT, RD_TX: begin
            if (state_q == RD_WAIT && RdData_Valid) rd_q <= RdData;
            if (rd_push) begin
              winc_q <= 1'b1;
              tx_q   <= rd_byte;
              cnt_q  <= cnt_q - CNT_ONE;
              if (cnt_q != CNT_ONE) begin
                rden_q <= 1'b1;
                addr_q <= ptr_q;
                ptr_q  <= ptr_q + ADDR_ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ALU_FUN    = alu_fun_q;
  assign EN         = en_q;
  assign CLK_EN     = clk_en_q;
  assign Address    = addr_q;
  assign WrEn       = wren_q;
  assign RdEn       = rden_q;
  assign WrData     = wrdata_q;
  assign TX_P_DATA  = tx_q;
  assign W_INC      = winc_q;
  assign clk_div_en = 1'b1;
  assign BUSY       = busy_q;
  assign ERR        = err_q;
endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed bench for sys_ctrl_burst: drives RX frames, plays register file / ALU / FIFO,
// and checks strobes, addresses and TX bytes against hand-computed values.
`timescale 1ns/1ps
module tb_sys_ctrl_burst;
  localparam int TO = 1024;

  logic       CLK = 1'b0, RST = 1'b1;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic       OUT_Valid = 1'b0;
  logic [7:0] RdData = '0;
  logic       RdData_Valid = 1'b0;
  logic       FIFO_FULL = 1'b0;
  logic [3:0] ALU_FUN;
  logic       EN, CLK_EN, WrEn, RdEn, W_INC, clk_div_en, BUSY, ERR;
  logic [3:0] Address;
  logic [7:0] WrData, TX_P_DATA;

  sys_ctrl_burst #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16), .ALU_FUN_WIDTH(4),
    .MAX_BURST(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .RdData(RdData), .RdData_Valid(RdData_Valid),
    .FIFO_FULL(FIFO_FULL), .ALU_FUN(ALU_FUN), .EN(EN), .CLK_EN(CLK_EN), .Address(Address),
    .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .TX_P_DATA(TX_P_DATA), .W_INC(W_INC),
    .clk_div_en(clk_div_en), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] wr_log[$];
  logic [7:0]  tx_log[$];
  logic [3:0]  rd_log[$];
  int          err_cnt = 0;

  // Passive log of strobes, taken slightly after the sampling edge used by the tasks.
  always @(negedge CLK) begin
    #2;
    if (WrEn)  wr_log.push_back({4'h0, Address, WrData});
    if (W_INC) tx_log.push_back(TX_P_DATA);
    if (RdEn)  rd_log.push_back(Address);
    if (ERR)   err_cnt++;
  end

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    tx_log.delete();
    rd_log.delete();
    err_cnt = 0;
  endtask

  function automatic logic [30:0] all_outs();
    return {ALU_FUN, EN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, W_INC, BUSY, ERR};
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (all_outs() !== 31'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    n_cmp++;
    if (clk_div_en !== 1'b1) begin
      n_bad++; $display("FAIL reset_clk_div_en: got %b expected 1", clk_div_en);
    end
    RST = 1'b0;
    @(negedge CLK);
    $display("reset: released");
  endtask

  task automatic test_write_read();
    clear_logs();
    send(8'hAA); send(8'h05); send(8'h3C);
    $display("frame: write AA 05 3C");
    n_cmp++;
    if ({WrEn, Address, WrData} !== {1'b1, 4'h5, 8'h3C}) begin
      n_bad++; $display("FAIL write_strobe: got %b/%h/%h expected 1/5/3c", WrEn, Address, WrData);
    end
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (wr_log.size() != 1 || wr_log[0] !== 16'h053C || BUSY !== 1'b0) begin
      n_bad++; $display("FAIL write_log: got %0d writes first %h busy %b expected 1 write 053c busy 0",
                        wr_log.size(), wr_log[0], BUSY);
    end
    send(8'hBB); send(8'h05);
    $display("frame: read BB 05");
    n_cmp++;
    if ({RdEn, Address} !== {1'b1, 4'h5}) begin
      n_bad++; $display("FAIL read_strobe: got %b/%h expected 1/5", RdEn, Address);
    end
    @(negedge CLK);
    RdData = 8'h3C; RdData_Valid = 1'b1;
    @(negedge CLK);
    RdData_Valid = 1'b0;
    n_cmp++;
    if ({W_INC, TX_P_DATA} !== {1'b1, 8'h3C}) begin
      n_bad++; $display("FAIL read_push: got %b/%h expected 1/3c", W_INC, TX_P_DATA);
    end
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (tx_log.size() != 1 || BUSY !== 1'b0) begin
      n_bad++; $display("FAIL read_count: got %0d pushes busy %b expected 1 push busy 0", tx_log.size(), BUSY);
    end
  endtask

  task automatic test_alu();
    int full_push;
    clear_logs();
    send(8'hCC); send(8'h10); send(8'h20); send(8'h00);
    $display("frame: alu CC 10 20 00");
    n_cmp++;
    if ({EN, ALU_FUN, CLK_EN} !== {1'b1, 4'h0, 1'b1}) begin
      n_bad++; $display("FAIL alu_launch: got %b/%h/%b expected 1/0/1", EN, ALU_FUN, CLK_EN);
    end
    n_cmp++;
    if (wr_log.size() != 2 || wr_log[0] !== 16'h0010 || wr_log[1] !== 16'h0120) begin
      n_bad++; $display("FAIL alu_operands: got %0d writes %h %h expected 0010 0120",
                        wr_log.size(), wr_log[0], wr_log[1]);
    end
    repeat (2) @(negedge CLK);
    ALU_OUT = 16'h0030; OUT_Valid = 1'b1;
    @(negedge CLK);
    OUT_Valid = 1'b0;
    n_cmp++;
    if ({W_INC, TX_P_DATA, CLK_EN} !== {1'b1, 8'h30, 1'b1}) begin
      n_bad++; $display("FAIL alu_byte0: got %b/%h/%b expected 1/30/1", W_INC, TX_P_DATA, CLK_EN);
    end
    @(negedge CLK);
    n_cmp++;
    if ({W_INC, TX_P_DATA, CLK_EN, BUSY} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL alu_byte1: got %b/%h/%b/%b expected 1/00/0/0", W_INC, TX_P_DATA, CLK_EN, BUSY);
    end
    // Second op without operands, with the FIFO full as the result arrives.
    clear_logs();
    send(8'hDD); send(8'h03);
    $display("frame: alu DD 03");
    n_cmp++;
    if ({EN, ALU_FUN, CLK_EN} !== {1'b1, 4'h3, 1'b1} || wr_log.size() != 0) begin
      n_bad++; $display("FAIL alu_nop_launch: got %b/%h/%b writes %0d expected 1/3/1 writes 0",
                        EN, ALU_FUN, CLK_EN, wr_log.size());
    end
    @(negedge CLK);
    FIFO_FULL = 1'b1; ALU_OUT = 16'hBEEF; OUT_Valid = 1'b1;
    @(negedge CLK);
    OUT_Valid = 1'b0;
    full_push = W_INC;
    @(negedge CLK);
    full_push += W_INC;
    FIFO_FULL = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (full_push != 0 || {W_INC, TX_P_DATA} !== {1'b1, 8'hEF}) begin
      n_bad++; $display("FAIL alu_stall_byte0: pushes while full %0d, got %b/%h expected 0 then 1/ef",
                        full_push, W_INC, TX_P_DATA);
    end
    @(negedge CLK);
    n_cmp++;
    if ({W_INC, TX_P_DATA, CLK_EN} !== {1'b1, 8'hBE, 1'b0}) begin
      n_bad++; $display("FAIL alu_stall_byte1: got %b/%h/%b expected 1/be/0", W_INC, TX_P_DATA, CLK_EN);
    end
  endtask

  task automatic test_burst_write_wrap();
    clear_logs();
    send(8'hEE); send(8'h0E); send(8'h03); send(8'h11); send(8'h22);
    n_cmp++;
    if (BUSY !== 1'b1) begin
      n_bad++; $display("FAIL burst_busy_mid: got %b expected 1", BUSY);
    end
    send(8'h33);
    $display("frame: burst write EE 0E 03 11 22 33");
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_bad++; $display("FAIL burst_busy_end: got %b expected 0", BUSY);
    end
    @(negedge CLK);
    n_cmp++;
    if (wr_log.size() != 3 || wr_log[0] !== 16'h0E11 || wr_log[1] !== 16'h0F22 || wr_log[2] !== 16'h0033) begin
      n_bad++; $display("FAIL burst_wrap: got %0d writes %h %h %h expected 0e11 0f22 0033",
                        wr_log.size(), wr_log[0], wr_log[1], wr_log[2]);
    end
  endtask

  task automatic test_back_to_back_read_backpressure();
    int full_push = 0;
    clear_logs();
    FIFO_FULL = 1'b1;
    send(8'hFF); send(8'h02); send(8'h02);
    $display("frame: burst read FF 02 02 with fifo full");
    n_cmp++;
    if ({RdEn, Address} !== {1'b1, 4'h2}) begin
      n_bad++; $display("FAIL bread_req0: got %b/%h expected 1/2", RdEn, Address);
    end
    @(negedge CLK);
    RdData = 8'hA1; RdData_Valid = 1'b1;
    @(negedge CLK);
    RdData_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      full_push += W_INC;
      @(negedge CLK);
    end
    n_cmp++;
    if (full_push != 0 || BUSY !== 1'b1) begin
      n_bad++; $display("FAIL bread_hold: got %0d pushes busy %b expected 0 pushes busy 1", full_push, BUSY);
    end
    FIFO_FULL = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({W_INC, TX_P_DATA, RdEn, Address} !== {1'b1, 8'hA1, 1'b1, 4'h3}) begin
      n_bad++; $display("FAIL bread_byte0: got %b/%h/%b/%h expected 1/a1/1/3", W_INC, TX_P_DATA, RdEn, Address);
    end
    @(negedge CLK);
    RdData = 8'hB2; RdData_Valid = 1'b1;
    @(negedge CLK);
    RdData_Valid = 1'b0;
    n_cmp++;
    if ({W_INC, TX_P_DATA, BUSY} !== {1'b1, 8'hB2, 1'b0}) begin
      n_bad++; $display("FAIL bread_byte1: got %b/%h/%b expected 1/b2/0", W_INC, TX_P_DATA, BUSY);
    end
    @(negedge CLK);
    n_cmp++;
    if (tx_log.size() != 2 || rd_log.size() != 2 || err_cnt != 0) begin
      n_bad++; $display("FAIL bread_totals: got %0d pushes %0d reads %0d errs expected 2 2 0",
                        tx_log.size(), rd_log.size(), err_cnt);
    end
  endtask

  task automatic test_errors();
    clear_logs();
    send(8'h55);
    $display("frame: bad command 55");
    n_cmp++;
    if ({ERR, BUSY} !== 2'b10) begin
      n_bad++; $display("FAIL err_badcmd: got err %b busy %b expected 1 0", ERR, BUSY);
    end
    send(8'hEE); send(8'h00); send(8'h09);
    $display("frame: burst write EE 00 09 over limit");
    n_cmp++;
    if ({ERR, BUSY} !== 2'b10) begin
      n_bad++; $display("FAIL err_len: got err %b busy %b expected 1 0", ERR, BUSY);
    end
    send(8'hEE); send(8'h00); send(8'h00);
    $display("frame: burst write EE 00 00 zero length");
    n_cmp++;
    if ({ERR, BUSY} !== 2'b00) begin
      n_bad++; $display("FAIL zero_len: got err %b busy %b expected 0 0", ERR, BUSY);
    end
    send(8'h44);
    @(negedge CLK);
    n_cmp++;
    if (wr_log.size() != 0 || err_cnt != 3) begin
      n_bad++; $display("FAIL err_totals: got %0d writes %0d errs expected 0 3", wr_log.size(), err_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    send(8'hBB);
    $display("frame: read BB then silence");
    repeat (TO - 1) @(negedge CLK);
    n_cmp++;
    if ({ERR, BUSY} !== 2'b01) begin
      n_bad++; $display("FAIL timeout_early: got err %b busy %b expected 0 1", ERR, BUSY);
    end
    @(negedge CLK);
    n_cmp++;
    if ({ERR, BUSY} !== 2'b10) begin
      n_bad++; $display("FAIL timeout_fire: got err %b busy %b expected 1 0", ERR, BUSY);
    end
    @(negedge CLK);
    n_cmp++;
    if (rd_log.size() != 0 || err_cnt != 1) begin
      n_bad++; $display("FAIL timeout_totals: got %0d reads %0d errs expected 0 1", rd_log.size(), err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    send(8'hCC); send(8'h10);
    $display("frame: CC 10 then reset");
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (all_outs() !== 31'h0 || clk_div_en !== 1'b1) begin
      n_bad++; $display("FAIL midframe_reset: got %h div %b expected 0 div 1", all_outs(), clk_div_en);
    end
    RST = 1'b0;
    @(negedge CLK);
    send(8'h20);
    n_cmp++;
    if ({ERR, WrEn, BUSY} !== 3'b100) begin
      n_bad++; $display("FAIL midframe_abort: got err %b wren %b busy %b expected 1 0 0", ERR, WrEn, BUSY);
    end
    @(negedge CLK);
    n_cmp++;
    if (wr_log.size() != 1) begin
      n_bad++; $display("FAIL midframe_writes: got %0d writes expected 1", wr_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alu();
    test_burst_write_wrap();
    test_back_to_back_read_backpressure();
    test_errors();
    test_timeout();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
